// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Purpose : Register map and CTRL bit layout of the timer peripheral. The same
//           offsets and bit indices are used by the firmware headers.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package timer_pkg;

  // Word offsets, decoded from addr_i[3:2]
  localparam logic [1:0] TIMER_CTRL  = 2'd0;
  localparam logic [1:0] TIMER_CMP   = 2'd1;
  localparam logic [1:0] TIMER_COUNT = 2'd2;
  localparam logic [1:0] TIMER_PRESC = 2'd3;

  // CTRL bit indices
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_PEND    = 2;
  localparam int CTRL_ONESHOT = 3;

  // Packed so that each field lands on its CTRL bit index
  typedef struct packed {
    logic oneshot;
    logic pend;
    logic ie;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/timer_if.sv
// -----------------------------------------------------------------------------
// timer_if
// Purpose : Bus-side signal bundle of the timer peripheral.
// Signals : addr_i    32  byte address (only [3:2] decoded by the timer)
//           data_i    32  write data
//           we_i       1  write enable, full-word writes
//           data_o    32  combinational read data
//           int_sig_o  1  level-high interrupt request
// Modports: master (bus / core side), slave (timer side)
// -----------------------------------------------------------------------------
interface timer_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        we_i;
  logic [31:0] data_o;
  logic        int_sig_o;

  modport master (
    output addr_i, data_i, we_i,
    input  data_o, int_sig_o
  );

  modport slave (
    input  addr_i, data_i, we_i,
    output data_o, int_sig_o
  );
endinterface

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Purpose : Divides the count rate of the timer. tick is high every cycle when
//           presc is 0, otherwise once every presc+1 enabled cycles.
// Ports   : clk, rst (async, active-high)
//           en        count enable; the divider is held at 0 while low
//           presc     divisor minus 1
//           presc_we  restart the divider (new divisor being written)
//           tick      count strobe for the timer
// -----------------------------------------------------------------------------
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               presc_we,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt;

  // With presc == 0 the divider never leaves 0, so tick stays high
  assign tick = (pcnt == presc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (!en || presc_we) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/timer.sv
// -----------------------------------------------------------------------------
// timer
// Purpose : Memory-mapped up-counter with compare/reload, one-shot mode, W1C
//           pending flag and a registered level interrupt.
//           Register map (addr_i[3:2]): 0 CTRL, 1 CMP, 2 COUNT, 3 PRESC.
// Ports   : clk        system clock
//           rst        asynchronous, active-high reset
//           bus        timer_if.slave (addr_i, data_i, we_i, data_o, int_sig_o)
// Config  : define TIMER_PRESCALER_EN to build the PRESC register and the
//           prescaler; without it the counter ticks every cycle and offset 3
//           reads 0 and ignores writes.
// -----------------------------------------------------------------------------
module timer
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic   clk,
  input  logic   rst,
  timer_if.slave bus
);

  logic [1:0]       off;
  logic             wr_ctrl;
  logic             wr_cmp;
  logic             wr_count;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] cmp;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] cmp_last;
  logic             tick;
  logic             match;
  logic             int_sig;
  logic [31:0]      rdata;
  logic             unused_addr;

  // Only the word offset is decoded; the remaining address bits alias
  assign off         = bus.addr_i[3:2];
  assign unused_addr = ^{bus.addr_i[31:4], bus.addr_i[1:0]};

  assign wr_ctrl  = bus.we_i && (off == TIMER_CTRL);
  assign wr_cmp   = bus.we_i && (off == TIMER_CMP);
  assign wr_count = bus.we_i && (off == TIMER_COUNT);

`ifdef TIMER_PRESCALER_EN
  logic               wr_presc;
  logic [PRESC_W-1:0] presc;

  assign wr_presc = bus.we_i && (off == TIMER_PRESC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (wr_presc) begin
      presc <= bus.data_i[PRESC_W-1:0];
    end
  end

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl.en),
    .presc    (presc),
    .presc_we (wr_presc),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // COUNT reaching CMP-1 on a tick reloads to 0, giving a period of CMP ticks.
  // CMP == 0 disables matching so the counter free-runs and wraps.
  assign cmp_last = cmp - CNT_W'(1);
  assign match    = ctrl.en && tick && (cmp != '0) && (count >= cmp_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl    <= '0;
      cmp     <= '0;
      count   <= '0;
      int_sig <= 1'b0;
    end else begin
      if (wr_cmp) begin
        cmp <= bus.data_i[CNT_W-1:0];
      end

      // A software write to COUNT overrides both reload and increment
      if (wr_count) begin
        count <= bus.data_i[CNT_W-1:0];
      end else if (match) begin
        count <= '0;
      end else if (ctrl.en && tick) begin
        count <= count + CNT_W'(1);
      end

      // Software-written EN beats the one-shot auto-clear
      if (wr_ctrl) begin
        ctrl.en      <= bus.data_i[CTRL_EN];
        ctrl.ie      <= bus.data_i[CTRL_IE];
        ctrl.oneshot <= bus.data_i[CTRL_ONESHOT];
      end else if (match && ctrl.oneshot) begin
        ctrl.en <= 1'b0;
      end

      // A match beats a simultaneous W1C so no event is lost
      if (match) begin
        ctrl.pend <= 1'b1;
      end else if (wr_ctrl && bus.data_i[CTRL_PEND]) begin
        ctrl.pend <= 1'b0;
      end

      int_sig <= ctrl.pend && ctrl.ie;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      TIMER_CTRL: begin
        rdata[CTRL_EN]      = ctrl.en;
        rdata[CTRL_IE]      = ctrl.ie;
        rdata[CTRL_PEND]    = ctrl.pend;
        rdata[CTRL_ONESHOT] = ctrl.oneshot;
      end
      TIMER_CMP:   rdata[CNT_W-1:0] = cmp;
      TIMER_COUNT: rdata[CNT_W-1:0] = count;
      default: begin
`ifdef TIMER_PRESCALER_EN
        rdata[PRESC_W-1:0] = presc;
`else
        rdata = '0;
`endif
      end
    endcase
  end

  assign bus.data_o    = rdata;
  assign bus.int_sig_o = int_sig;

endmodule

// File: tb/tb_timer.sv
// -----------------------------------------------------------------------------
// tb_timer
// Purpose : Self-checking bench for timer (default parameters). Directed
//           scenarios first, then randomized bus traffic compared each cycle
//           against a behavioural model. Honours TIMER_PRESCALER_EN.
// -----------------------------------------------------------------------------
module tb_timer;
  import timer_pkg::*;

  logic clk;
  logic rst;

  timer_if bus ();

  timer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  bit          m_en, m_ie, m_pend, m_os, m_int;
  int unsigned m_cmp, m_cnt, m_presc, m_pcnt;

  function automatic logic [31:0] m_read(input logic [1:0] off);
    case (off)
      TIMER_CTRL:  return {28'd0, m_os, m_pend, m_ie, m_en};
      TIMER_CMP:   return m_cmp;
      TIMER_COUNT: return m_cnt;
      default: begin
`ifdef TIMER_PRESCALER_EN
        return m_presc;
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_ie = 0; m_pend = 0; m_os = 0; m_int = 0;
    m_cmp = 0; m_cnt = 0; m_presc = 0; m_pcnt = 0;
  endtask

  // One clock edge of the peripheral, from the rules of the register map
  task automatic model_step();
    logic [31:0] a, d;
    bit          we, t, hit;
    logic [1:0]  off;
    int unsigned n_cnt, n_pcnt, n_cmp, n_presc;
    bit          n_en, n_ie, n_os, n_pend;
    a = bus.addr_i; d = bus.data_i; we = bus.we_i; off = a[3:2];
`ifdef TIMER_PRESCALER_EN
    t = (m_pcnt == m_presc);
`else
    t = 1;
`endif
    // The period ends once COUNT+1 reaches CMP (64-bit to avoid wrap effects)
    hit = m_en && t && (m_cmp != 0) && (longint'(m_cnt) + 1 >= longint'(m_cmp));

    n_cmp = (we && off == TIMER_CMP) ? d : m_cmp;
    if (we && off == TIMER_COUNT) n_cnt = d;
    else if (hit)                 n_cnt = 0;
    else if (m_en && t)           n_cnt = m_cnt + 1;
    else                          n_cnt = m_cnt;

    n_en = m_en; n_ie = m_ie; n_os = m_os;
    if (we && off == TIMER_CTRL) begin
      n_en = d[0]; n_ie = d[1]; n_os = d[3];
    end else if (hit && m_os) begin
      n_en = 0;
    end
    n_pend = hit ? 1'b1 : ((we && off == TIMER_CTRL && d[2]) ? 1'b0 : m_pend);

    n_presc = m_presc;
`ifdef TIMER_PRESCALER_EN
    if (we && off == TIMER_PRESC) n_presc = d & 32'h0000_FFFF;
`endif
    if (!m_en || (we && off == TIMER_PRESC)) n_pcnt = 0;
    else                                     n_pcnt = (m_pcnt + 1) % (m_presc + 1);

    m_int = m_pend && m_ie;
    m_cnt = n_cnt; m_cmp = n_cmp; m_presc = n_presc; m_pcnt = n_pcnt;
    m_en = n_en; m_ie = n_ie; m_os = n_os; m_pend = n_pend;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_addr(input logic [1:0] off);
    logic [31:0] a;
    a = $urandom;
    a[3:2] = off;
    bus.addr_i = a;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d);
    set_addr(off);
    bus.data_i = d;
    bus.we_i   = 1'b1;
    cycle();
    bus.we_i   = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
    set_addr(off);
    #1;
    check(tag, bus.data_o, exp);
  endtask

  initial begin
    bus.addr_i = '0;
    bus.data_i = '0;
    bus.we_i   = 1'b0;
    rst        = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk_reg("rst_ctrl", TIMER_CTRL, 32'd0);
    chk_reg("rst_cmp", TIMER_CMP, 32'd0);
    chk_reg("rst_count", TIMER_COUNT, 32'd0);
    chk_reg("rst_presc", TIMER_PRESC, 32'd0);
    check("rst_int", 32'(bus.int_sig_o), 32'd0);

    // Periodic: CMP=5 gives 0,1,2,3,4,0,...
    wr(TIMER_CMP, 32'd5);
    wr(TIMER_CTRL, 32'h3);
    chk_reg("per_c0", TIMER_COUNT, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk_reg("per_cnt", TIMER_COUNT, 32'(i));
    end
    cycle();
    chk_reg("per_wrap", TIMER_COUNT, 32'd0);
    chk_reg("per_ctrl", TIMER_CTRL, 32'h7);
    check("per_int_lag", 32'(bus.int_sig_o), 32'd0);
    cycle();
    check("per_int", 32'(bus.int_sig_o), 32'd1);
    chk_reg("per_c1", TIMER_COUNT, 32'd1);

    // Asynchronous reset mid-count with PEND set
    rst = 1'b1;
    #1;
    check("arst_int", 32'(bus.int_sig_o), 32'd0);
    chk_reg("arst_ctrl", TIMER_CTRL, 32'd0);
    chk_reg("arst_cmp", TIMER_CMP, 32'd0);
    chk_reg("arst_count", TIMER_COUNT, 32'd0);
    chk_reg("arst_presc", TIMER_PRESC, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // One-shot, then W1C
    wr(TIMER_CMP, 32'd3);
    wr(TIMER_CTRL, 32'hB);
    chk_reg("os_c0", TIMER_COUNT, 32'd0);
    cycle();
    chk_reg("os_c1", TIMER_COUNT, 32'd1);
    cycle();
    chk_reg("os_c2", TIMER_COUNT, 32'd2);
    cycle();
    chk_reg("os_match_cnt", TIMER_COUNT, 32'd0);
    chk_reg("os_match_ctrl", TIMER_CTRL, 32'hE);
    cycle();
    chk_reg("os_hold", TIMER_COUNT, 32'd0);
    check("os_int", 32'(bus.int_sig_o), 32'd1);
    wr(TIMER_CTRL, 32'h4);
    chk_reg("w1c_ctrl", TIMER_CTRL, 32'h0);
    check("w1c_int_lag", 32'(bus.int_sig_o), 32'd1);
    cycle();
    check("w1c_int_fall", 32'(bus.int_sig_o), 32'd0);

    // Collisions with a match (CMP=3)
    wr(TIMER_CTRL, 32'h3);
    repeat (5) cycle();
    chk_reg("col_pre", TIMER_COUNT, 32'd2);
    wr(TIMER_CTRL, 32'h7);
    chk_reg("col_w1c_pend", TIMER_CTRL, 32'h7);
    chk_reg("col_w1c_cnt", TIMER_COUNT, 32'd0);
    wr(TIMER_CTRL, 32'h7);
    chk_reg("col_clear", TIMER_CTRL, 32'h3);
    cycle();
    wr(TIMER_COUNT, 32'h10);
    chk_reg("col_cnt_wr", TIMER_COUNT, 32'h10);
    chk_reg("col_cnt_pend", TIMER_CTRL, 32'h7);
    wr(TIMER_CTRL, 32'h0);
    wr(TIMER_CTRL, 32'h4);
    wr(TIMER_COUNT, 32'd2);
    wr(TIMER_CTRL, 32'h9);
    wr(TIMER_CTRL, 32'h9);
    chk_reg("col_os_en", TIMER_CTRL, 32'hD);

    // Wrap with CMP=0
    wr(TIMER_CTRL, 32'h0);
    wr(TIMER_CTRL, 32'h4);
    wr(TIMER_CMP, 32'd0);
    wr(TIMER_COUNT, 32'hFFFF_FFFE);
    wr(TIMER_CTRL, 32'h1);
    chk_reg("wrap_fe", TIMER_COUNT, 32'hFFFF_FFFE);
    cycle();
    chk_reg("wrap_ff", TIMER_COUNT, 32'hFFFF_FFFF);
    cycle();
    chk_reg("wrap_0", TIMER_COUNT, 32'd0);
    cycle();
    chk_reg("wrap_1", TIMER_COUNT, 32'd1);
    chk_reg("wrap_nopend", TIMER_CTRL, 32'h1);

    // Prescaler
    wr(TIMER_CTRL, 32'h0);
    wr(TIMER_COUNT, 32'd0);
`ifdef TIMER_PRESCALER_EN
    wr(TIMER_PRESC, 32'd2);
    wr(TIMER_CMP, 32'd2);
    chk_reg("ps_rd", TIMER_PRESC, 32'd2);
    wr(TIMER_CTRL, 32'h1);
    chk_reg("ps_c0", TIMER_COUNT, 32'd0);
    repeat (2) cycle();
    chk_reg("ps_c0b", TIMER_COUNT, 32'd0);
    cycle();
    chk_reg("ps_c1", TIMER_COUNT, 32'd1);
    repeat (2) cycle();
    chk_reg("ps_c1b", TIMER_COUNT, 32'd1);
    cycle();
    chk_reg("ps_wrap", TIMER_COUNT, 32'd0);
    chk_reg("ps_pend", TIMER_CTRL, 32'h5);
`else
    wr(TIMER_PRESC, 32'h7);
    chk_reg("nops_rd", TIMER_PRESC, 32'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, d;
      a = $urandom;
      case (a[3:2])
        TIMER_CTRL:  d = $urandom;
        TIMER_CMP:   d = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 6));
        TIMER_COUNT: begin
          case ($urandom_range(0, 2))
            0:       d = 32'($urandom_range(0, 8));
            1:       d = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            default: d = $urandom;
          endcase
        end
        default:     d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
      endcase
      bus.addr_i = a;
      bus.data_i = d;
      bus.we_i   = ($urandom_range(0, 3) == 0);
      cycle();
      bus.we_i   = 1'b0;
      check("rand_int", 32'(bus.int_sig_o), 32'(m_int));
      a = $urandom;
      bus.addr_i = a;
      #1;
      check("rand_rd", bus.data_o, m_read(a[3:2]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
